aes_encr_iter: RTL and testbench

AES_ENCR_ITER -- requirements
Module: aes_encr_iter

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_encr_round.sv | 46 ++++
 rtl/aes_encr_iter.sv | 118 +++++++++++
 tb/tb_aes_encr_iter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryptor.
// Contents:
//   NR          - number of rounds for AES-128 (10)
//   aes_state_e - control FSM states (IDLE, RUN, DONE)
//   SBOX        - forward S-box, indexed by the input byte
//   RCON        - round constants, indexed by round number 1..10 (entry 0 and 11..15 unused)
//   sbox()      - forward S-box lookup
//   rcon()      - round-constant lookup
//   xtime()     - multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Sized to the full 4-bit round counter so lookups never go out of range;
    // the round counter only ever holds 1..10.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        return RCON[rnd];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_encr_round.sv
// One forward AES round, purely combinational.
// Ports:
//   state_in  [127:0] - round input state, byte 0 in bits [127:120], column-major
//   rk        [127:0] - round key applied by AddRoundKey
//   last      1       - final round: MixColumns is bypassed
//   state_out [127:0] - SubBytes -> ShiftRows -> MixColumns (unless last) -> AddRoundKey
module aes_encr_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // Byte i = row (i%4), column (i/4) lives in bits [127-8i -: 8].
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
    end

    // Row r rotates left by r columns: new (r,c) takes old (r,(c+r)%4).
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[127-32*c -: 8];
        assign a1 = sr[119-32*c -: 8];
        assign a2 = sr[111-32*c -: 8];
        assign a3 = sr[103-32*c -: 8];
        assign mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign state_out = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_encr_iter.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// A block is accepted in IDLE, runs ten rounds in RUN, and is presented in DONE
// until the consumer takes it.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   in_valid   - plaintext and key presented
//   in_ready   - high only in IDLE
//   in  [127:0]- plaintext, byte 0 in bits [127:120]
//   key [127:0]- cipher key, same byte order
//   out_valid  - high only in DONE
//   out_ready  - consumer accepts the ciphertext
//   out [127:0]- ciphertext (state register, visible in every state)
module aes_encr_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);

    aes_state_e   fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [127:0] state_d;
    logic [127:0] rk_d;
    logic         last;

    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  tmp_w;
    logic [31:0]  w0, w1, w2, w3;

    // Next round key: temp = SubWord(RotWord(w3)) ^ Rcon, then the XOR chain.
    always_comb begin
        rot_w = {rk_q[23:0], rk_q[31:24]};
        sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        tmp_w = sub_w ^ {rcon(rnd_q), 24'h000000};
        w0    = rk_q[127:96] ^ tmp_w;
        w1    = rk_q[95:64]  ^ w0;
        w2    = rk_q[63:32]  ^ w1;
        w3    = rk_q[31:0]   ^ w2;
        rk_d  = {w0, w1, w2, w3};
    end

    assign last = (rnd_q == 4'(NR));

    aes_encr_round u_round (
        .state_in  (state_q),
        .rk        (rk_d),
        .last      (last),
        .state_out (state_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd1;
            state_q     <= '0;
            rk_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= in ^ key;
                        rk_q       <= key;
                        rnd_q      <= 4'd1;
                        fsm_q      <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    rk_q    <= rk_d;
                    // The counter returns to 1 after the final round instead of
                    // stepping to 11, so it stays within 1..10.
                    if (last) begin
                        rnd_q       <= 4'd1;
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    rnd_q       <= 4'd1;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = state_q;

endmodule

// File: tb/tb_aes_encr_iter.sv
// Self-checking bench for aes_encr_iter: directed known-answer vectors, handshake
// corner cases, and random blocks compared with a bench-side AES model whose
// S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_encr_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_encr_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (ct)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] sb_t [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s  [16];
        logic [7:0]   ns [16];
        logic [7:0]   kk [16];
        logic [7:0]   t  [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            kk[i] = k[127-8*i -: 8];
            s[i]  = p[127-8*i -: 8] ^ kk[i];
        end
        rc = 8'h01;
        for (int rd = 1; rd <= 10; rd++) begin
            t[0] = sb_t[kk[13]] ^ rc;
            t[1] = sb_t[kk[14]];
            t[2] = sb_t[kk[15]];
            t[3] = sb_t[kk[12]];
            for (int j = 0; j < 4; j++) kk[j] = kk[j] ^ t[j];
            for (int j = 4; j < 16; j++) kk[j] = kk[j] ^ kk[j-4];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    ns[r+4*c] = sb_t[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kk[i];
            rc = xt(rc);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge while idle with out_ready=1. lat counts negedges from
    // the accept edge to the first one showing out_valid; ends back in IDLE.
    task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                             output int lat, output logic [127:0] res);
        pt       = p;
        key      = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = ct;
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           bad;
        int           n;
        logic [127:0] res;
        int           acc [2];
        logic [127:0] outs [2];
        int           na;
        int           no;

        for (int i = 0; i < 256; i++) sb_t[i] = sbox_m(8'(i));

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pt = '0; key = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out", ct, 128'd0);

        // Known-answer table, including the exact accept-to-valid latency
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_kat%0d", i), aes_ref(vecs[i].pt, vecs[i].key), vecs[i].ct);
            run_block(vecs[i].pt, vecs[i].key, lat, res);
            chk($sformatf("kat%0d_out", i), res, vecs[i].ct);
            chk($sformatf("kat%0d_latency", i), 128'(lat), 128'd11);
        end

        // Backpressure: output held 20 cycles, new requests ignored meanwhile
        out_ready = 1'b0;
        pt = vecs[1].pt; key = vecs[1].key; in_valid = 1'b1;
        @(negedge clk);
        pt = vecs[0].pt; key = vecs[0].key;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ct !== vecs[1].ct || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            pt = rnd128(); key = rnd128();
            @(negedge clk);
        end
        chk("bp_hold_violations", 128'(bad), 128'd0);
        chk("bp_out", ct, vecs[1].ct);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);

        // Inputs scrambled every cycle after accept, in_valid kept high
        pt = vecs[0].pt; key = vecs[0].key; in_valid = 1'b1;
        @(negedge clk);
        bad = 0; n = 0;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) bad++;
            pt = rnd128(); key = rnd128();
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (in_ready !== 1'b0) bad++;
        chk("scramble_extra_accepts", 128'(bad), 128'd0);
        chk("scramble_out", ct, vecs[0].ct);
        @(negedge clk);

        // Reset in the middle of RUN (round counter at 5)
        pt = vecs[1].pt; key = vecs[1].key; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out", ct, 128'd0);
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("midrst_no_residual", 128'(bad), 128'd0);
        run_block(vecs[1].pt, vecs[1].key, lat, res);
        chk("midrst_fresh_out", res, vecs[1].ct);

        // Back-to-back with in_valid held high
        na = 0; no = 0;
        acc[0] = -1; acc[1] = -1;
        outs[0] = 'x; outs[1] = 'x;
        pt = vecs[0].pt; key = vecs[0].key; in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && no < 2; cyc++) begin
            if (na == 2) in_valid = 1'b0;
            if (in_valid && in_ready && na < 2) begin acc[na] = cyc; na++; end
            if (out_valid && no < 2) begin outs[no] = ct; no++; end
            @(negedge clk);
            if (na == 1) begin pt = vecs[1].pt; key = vecs[1].key; end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(na), 128'd2);
        chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_out0", outs[0], vecs[0].ct);
        chk("b2b_out1", outs[1], vecs[1].ct);

        // Random blocks against the model
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] p;
            logic [127:0] k;
            p = rnd128();
            k = rnd128();
            run_block(p, k, lat, res);
            chk($sformatf("rand%0d", i), res, aes_ref(p, k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
